// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one burst-oriented memory port between an instruction cache (reads
//   only) and a data cache (fills and writebacks). Requests are arbitrated in
//   IDLE only, round-robin on a tie, and the winner owns the port until its
//   whole LINE_WORDS-beat burst has transferred.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   i_req/i_addr             I-cache line-fill request and line base address
//   i_rvalid/i_rdata/i_done  I-cache fill beats and final-beat pulse
//   d_req/d_we/d_addr        D-cache request (d_we = 1 for writeback)
//   d_wdata/d_wpop           D-cache writeback beat and its consume strobe
//   d_rvalid/d_rdata/d_done  D-cache fill beats and final-beat pulse
//   mem_cmd_*                burst command to memory (valid/ready handshake)
//   mem_w*                   write beats to memory (valid/ready handshake)
//   mem_rvalid/mem_rdata     read beats from memory (no back-pressure)

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction-cache requester
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_done,
  // data-cache requester
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_wpop,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  // memory command
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
  // memory data
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, CMD, READ, WRITE} state_t;

  state_t                state;
  logic                  owner;       // 0 = I-cache, 1 = D-cache
  logic                  last_owner;  // most recent grant, for round-robin
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;

  logic winner;      // 1 = D-cache wins this IDLE cycle
  logic beat;        // one beat transfers this cycle
  logic last_beat;   // and it is the final beat of the line

  // On a tie the requester that did not go last wins; a lone request always wins.
  assign winner    = d_req & (~i_req | ~last_owner);

  // Memory strobes are only honoured in the state that expects them.
  assign beat      = ((state == READ) & mem_rvalid) | ((state == WRITE) & mem_wready);
  assign last_beat = beat & (cnt == LAST_CNT);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would make the result depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            owner      <= winner;
            last_owner <= winner;
            addr_q     <= winner ? d_addr : i_addr;
            we_q       <= winner & d_we;  // the I-cache only ever reads
            cnt        <= '0;
            state      <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) state <= we_q ? WRITE : READ;
        end
        READ, WRITE: begin
          if (beat) begin
            cnt <= cnt + CNT_W'(1);       // wraps to 0 on the final beat
            if (last_beat) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output is given a default before any condition, so no path
  // through this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    mem_cmd_valid = (state == CMD);
    mem_cmd_we    = we_q;
    mem_cmd_addr  = addr_q;
    mem_wvalid    = (state == WRITE);
    mem_wdata     = d_wdata;
    i_rdata       = mem_rdata;
    d_rdata       = mem_rdata;
    i_rvalid      = 1'b0;
    d_rvalid      = 1'b0;
    i_done        = 1'b0;
    d_done        = 1'b0;
    d_wpop        = 1'b0;
    if (state == READ) begin
      i_rvalid = mem_rvalid & ~owner;
      d_rvalid = mem_rvalid &  owner;
    end
    if (state == WRITE) begin
      d_wpop = mem_wready;
    end
    if (last_beat) begin
      i_done = ~owner;
      d_done =  owner;
    end
  end

endmodule
